config_write_sequencer: RTL

Host-side initiator for the DSP chiplet's mode configuration register. It accepts a new config value over a valid/ready request port and issues a single-cycle write strobe plus data to the register. It then waits a settle window, reads back the register's current mode output and compares it with the request. On mismatch it retries up to a bounded count, then reports done or error.

---
 rtl/config_write_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/config_write_sequencer.sv
// config_write_sequencer
//
// Host-side initiator for the DSP chiplet's mode configuration register.
// Accepts a config word over a valid/ready port, issues a one-cycle write
// strobe with data, waits a settle window, reads the register back, and
// retries on mismatch up to a bounded count before reporting done or error.
//
// Build option:
//   CFG_SEQ_VERIFY_EN  defined   -> WRITE, SETTLE, CHECK with readback/retry
//                      undefined -> WRITE goes straight back to IDLE with a
//                                   done pulse; error and retry_count are 0
//                                   and cfg_config_mode is ignored
//
// Ports:
//   clk               system clock, rising edge
//   reset_n           synchronous reset, active low
//   req_valid         host offers a new config value
//   req_ready         sequencer can accept (IDLE only)
//   req_config        requested config value, sampled at accept
//   cfg_write_enable  one-cycle write strobe to the config register
//   cfg_config_in     data to the config register, held between strobes
//   cfg_config_mode   readback of the register's current value
//   busy              request in flight
//   done              one-cycle pulse: write verified
//   error             one-cycle pulse: retries exhausted
//   retry_count       re-writes used by the current or last request
//
// All outputs are registered.

module config_write_sequencer #(
  parameter int CFG_W         = 5,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CFG_W-1:0] req_config,
  output logic             cfg_write_enable,
  output logic [CFG_W-1:0] cfg_config_in,
  input  logic [CFG_W-1:0] cfg_config_mode,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       retry_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
`ifdef CFG_SEQ_VERIFY_EN
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_CHECK  = 2'd3;

  // Counter is loaded with SETTLE_CYCLES-1 in WRITE and SETTLE exits on
  // zero, giving exactly SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);
`endif

  logic [1:0]       state_q,  state_d;
  logic             ready_q,  ready_d;
  logic             we_q,     we_d;
  logic [CFG_W-1:0] cfg_in_q, cfg_in_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

`ifdef CFG_SEQ_VERIFY_EN
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [3:0]       settle_q, settle_d;
  logic [3:0]       retry_q,  retry_d;
  logic             error_q,  error_d;
`else
  // Readback and the verify parameters have no function in this build.
  logic [CFG_W-1:0] unused_cfg_mode;
  localparam int unused_params = SETTLE_CYCLES + MAX_RETRY;
  assign unused_cfg_mode = cfg_config_mode;
`endif

  // Next-state logic. The strobe and its data are computed on the transition
  // into WRITE so that the registered outputs are valid during WRITE itself.
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    cfg_in_d = cfg_in_q;
    done_d   = 1'b0;
`ifdef CFG_SEQ_VERIFY_EN
    shadow_d = shadow_q;
    settle_d = settle_q;
    retry_d  = retry_q;
    error_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d  = ST_WRITE;
          we_d     = 1'b1;
          cfg_in_d = req_config;
`ifdef CFG_SEQ_VERIFY_EN
          shadow_d = req_config;
          retry_d  = '0;
`endif
        end
      end

      ST_WRITE: begin
`ifdef CFG_SEQ_VERIFY_EN
        settle_d = SETTLE_INIT;
        state_d  = ST_SETTLE;
`else
        state_d  = ST_IDLE;
        done_d   = 1'b1;
`endif
      end

`ifdef CFG_SEQ_VERIFY_EN
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if (cfg_config_mode == shadow_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (retry_q < MAX_RETRY_L) begin
          retry_d  = retry_q + 4'd1;
          state_d  = ST_WRITE;
          we_d     = 1'b1;
          cfg_in_d = shadow_q;
        end else begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs follow the state being entered so they line up with it.
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      cfg_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CFG_SEQ_VERIFY_EN
      shadow_q <= '0;
      settle_q <= '0;
      retry_q  <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      cfg_in_q <= cfg_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef CFG_SEQ_VERIFY_EN
      shadow_q <= shadow_d;
      settle_q <= settle_d;
      retry_q  <= retry_d;
      error_q  <= error_d;
`endif
    end
  end

  assign req_ready        = ready_q;
  assign cfg_write_enable = we_q;
  assign cfg_config_in    = cfg_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
`ifdef CFG_SEQ_VERIFY_EN
  assign error            = error_q;
  assign retry_count      = retry_q;
`else
  assign error            = 1'b0;
  assign retry_count      = '0;
`endif

endmodule
